// File: rtl/proc_loader_pkg.sv
// ============================================================================
//  Module   : proc_loader_pkg
//  Purpose  : Shared state encoding and word-geometry constants for the
//             boot-time program loader.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_loader_pkg;

    typedef enum logic [2:0] {
        HDR    = 3'd0,
        DATA   = 3'd1,
        WRITE  = 3'd2,
        VERIFY = 3'd3,
        RUN    = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam int BYTES_PER_WORD  = 4;
    localparam int WORD_BYTES_LOG2 = 2;

endpackage : proc_loader_pkg

`default_nettype wire

// File: rtl/proc_loader_asm.sv
// ============================================================================
//  Module   : proc_loader_asm
//  Purpose  : 4-byte little-endian shift assembler; first byte lands in [7:0].
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_loader_asm
    import proc_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        shift_en,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        full
);

    logic [WORD_BYTES_LOG2-1:0] r_byte_cnt;
    logic [31:0]                r_word;
    logic [31:0]                w_shifted;

    assign w_shifted = {byte_in, r_word[31:8]};

    // The counter is exactly log2(bytes) wide, so it wraps to 0 on the 4th shift.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_byte_cnt <= '0;
            r_word     <= '0;
        end else if (shift_en) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
            r_word     <= w_shifted;
        end
    end

    // Word output includes the byte being shifted so callers can act on it in the same cycle.
    assign word_out = shift_en ? w_shifted : r_word;
    assign full     = shift_en && (r_byte_cnt == WORD_BYTES_LOG2'(BYTES_PER_WORD - 1));

endmodule : proc_loader_asm

`default_nettype wire

// File: rtl/proc_loader.sv
// ============================================================================
//  Module   : proc_loader
//  Purpose  : Loads a length-prefixed little-endian word stream into memory,
//             then releases the processor from reset.
//             Optional read-back check: define PROC_LOADER_VERIFY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_loader
    import proc_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [7:0]  in_data,
    output logic        ext_dmemreq_val,
    output logic        ext_dmemreq_type,
    output logic [31:0] ext_dmemreq_addr,
    output logic [31:0] ext_dmemreq_wdata,
    input  logic [31:0] ext_dmemreq_rdata,
    output logic        proc_rst,
    output logic        done,
    output logic        error
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_word_cnt;
    logic        r_proc_rst;
    logic        r_done;

    logic        w_hs;
    logic        w_hdr_shift;
    logic        w_dat_shift;
    logic [31:0] w_count;
    logic        w_hdr_full;
    logic [31:0] w_word;
    logic        w_dat_full;
    logic [31:0] w_addr;
    logic        w_last;

    assign in_rdy      = (r_state == HDR) || (r_state == DATA);
    assign w_hs        = in_val && in_rdy;
    assign w_hdr_shift = w_hs && (r_state == HDR);
    assign w_dat_shift = w_hs && (r_state == DATA);

    proc_loader_asm u_hdr_asm (
        .clk      (clk),
        .rst      (rst),
        .shift_en (w_hdr_shift),
        .clear    (1'b0),
        .byte_in  (in_data),
        .word_out (w_count),
        .full     (w_hdr_full)
    );

    // Parking the data assembler in HDR keeps leftovers of an abandoned load out of the next word.
    proc_loader_asm u_dat_asm (
        .clk      (clk),
        .rst      (rst),
        .shift_en (w_dat_shift),
        .clear    (r_state == HDR),
        .byte_in  (in_data),
        .word_out (w_word),
        .full     (w_dat_full)
    );

    assign w_addr = BASE_ADDR + (r_word_cnt << WORD_BYTES_LOG2);
    assign w_last = ((r_word_cnt + 32'd1) == w_count);

`ifndef PROC_LOADER_VERIFY_EN
    logic w_unused_rdata;
    assign w_unused_rdata = ^ext_dmemreq_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= HDR;
            r_word_cnt <= '0;
            r_proc_rst <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_proc_rst <= (r_state != RUN);
            r_done     <= (r_state == RUN);
`ifdef PROC_LOADER_VERIFY_EN
            if (r_state == VERIFY) begin
                r_word_cnt <= r_word_cnt + 32'd1;
            end
`else
            if (r_state == WRITE) begin
                r_word_cnt <= r_word_cnt + 32'd1;
            end
`endif
        end
    end

    always_comb begin
        w_next            = r_state;
        ext_dmemreq_val   = 1'b0;
        ext_dmemreq_type  = 1'b0;
        ext_dmemreq_addr  = '0;
        ext_dmemreq_wdata = '0;
        error             = 1'b0;
        case (r_state)
            HDR: begin
                if (w_hdr_full) begin
                    if (w_count == 32'd0) begin
                        w_next = RUN;
                    end else if (w_count > 32'(MAX_WORDS)) begin
                        w_next = ERR;
                    end else begin
                        w_next = DATA;
                    end
                end
            end
            DATA: begin
                if (w_dat_full) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                ext_dmemreq_val   = 1'b1;
                ext_dmemreq_type  = 1'b1;
                ext_dmemreq_addr  = w_addr;
                ext_dmemreq_wdata = w_word;
`ifdef PROC_LOADER_VERIFY_EN
                w_next = VERIFY;
`else
                w_next = w_last ? RUN : DATA;
`endif
            end
`ifdef PROC_LOADER_VERIFY_EN
            VERIFY: begin
                ext_dmemreq_val  = 1'b1;
                ext_dmemreq_addr = w_addr;
                if (ext_dmemreq_rdata != w_word) begin
                    w_next = ERR;
                end else begin
                    w_next = w_last ? RUN : DATA;
                end
            end
`endif
            RUN: begin
                w_next = RUN;
            end
            ERR: begin
                error  = 1'b1;
                w_next = ERR;
            end
            default: begin
                w_next = HDR;
            end
        endcase
    end

    assign proc_rst = r_proc_rst;
    assign done     = r_done;

endmodule : proc_loader

`default_nettype wire

// File: tb/tb_proc_loader.sv
// ============================================================================
//  Module   : tb_proc_loader
//  Purpose  : Randomized self-checking bench for proc_loader against a
//             stream-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_proc_loader;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          MAXW = 1024;
`ifdef PROC_LOADER_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic        typ;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_val = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_rdy;
    logic        ext_dmemreq_val;
    logic        ext_dmemreq_type;
    logic [31:0] ext_dmemreq_addr;
    logic [31:0] ext_dmemreq_wdata;
    logic [31:0] ext_dmemreq_rdata;
    logic        proc_rst;
    logic        done;
    logic        error;

    int   n_chk  = 0;
    int   n_pass = 0;
    bit   corrupt = 1'b0;
    req_t obs_q[$];
    req_t exp_q[$];
    logic [31:0] mem [0:63];
    logic [31:0] w_off;
    logic [5:0]  w_idx;

    always #5 clk = ~clk;

    proc_loader #(
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_val            (in_val),
        .in_rdy            (in_rdy),
        .in_data           (in_data),
        .ext_dmemreq_val   (ext_dmemreq_val),
        .ext_dmemreq_type  (ext_dmemreq_type),
        .ext_dmemreq_addr  (ext_dmemreq_addr),
        .ext_dmemreq_wdata (ext_dmemreq_wdata),
        .ext_dmemreq_rdata (ext_dmemreq_rdata),
        .proc_rst          (proc_rst),
        .done              (done),
        .error             (error)
    );

    // Memory model: combinational read, optionally flipping bit 0 of word 0.
    assign w_off = ext_dmemreq_addr - BASE;
    assign w_idx = w_off[7:2];
    assign ext_dmemreq_rdata = mem[w_idx] ^ ((corrupt && ext_dmemreq_addr == BASE) ? 32'd1 : 32'd0);

    always @(posedge clk) begin
        if (ext_dmemreq_val && ext_dmemreq_type) mem[w_idx] <= ext_dmemreq_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    always @(negedge clk) begin
        if (!rst && ext_dmemreq_val) begin
            obs_q.push_back({ext_dmemreq_type, ext_dmemreq_addr, ext_dmemreq_wdata});
            check("rdy_during_req", 32'(in_rdy), 32'd0);
        end
    end

    function automatic bq_t add_word(bq_t q, logic [31:0] w);
        bq_t r = q;
        for (int b = 0; b < 4; b++) r.push_back(w[8*b +: 8]);
        return r;
    endfunction

    // Reference: expected request list, outcome and bytes the loader will consume.
    task automatic build_model(input bq_t s, input bit corr, output bit err,
                               output int consumed, output int nwords);
        logic [31:0] n;
        logic [31:0] w;
        exp_q.delete();
        n        = {s[3], s[2], s[1], s[0]};
        err      = 1'b0;
        consumed = 4;
        nwords   = 0;
        if (n > 32'(MAXW)) begin
            err = 1'b1;
            return;
        end
        nwords = int'(n);
        for (int i = 0; i < nwords; i++) begin
            w = {s[4+4*i+3], s[4+4*i+2], s[4+4*i+1], s[4+4*i]};
            exp_q.push_back({1'b1, BASE + 32'(4*i), w});
            consumed += 4;
            if (VER) begin
                exp_q.push_back({1'b0, BASE + 32'(4*i), 32'h0});
                if (corr && i == 0) begin
                    err = 1'b1;
                    return;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        in_val = 1'b0;
        @(negedge clk);
        check("rst_in_rdy",   32'(in_rdy),          32'd1);
        check("rst_proc_rst", 32'(proc_rst),        32'd1);
        check("rst_done",     32'(done),            32'd0);
        check("rst_error",    32'(error),           32'd0);
        check("rst_val",      32'(ext_dmemreq_val), 32'd0);
        obs_q.delete();
        rst = 1'b0;
    endtask

    // Returns just after the handshake edge with in_val already dropped.
    task automatic send_byte(input logic [7:0] b, input int gap_max, output bit ok);
        int gaps;
        gaps = $urandom_range(0, gap_max);
        ok   = 1'b0;
        @(negedge clk);
        in_val = 1'b0;
        repeat (gaps) @(negedge clk);
        in_val  = 1'b1;
        in_data = b;
        for (int t = 0; t < 50; t++) begin
            if (in_rdy) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1 in_val = 1'b0;
        if (!ok) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_case(input string name, input bq_t prefix, input bq_t s,
                            input int gap, input bit corr);
        bit err;
        bit ok;
        int consumed;
        int nwords;
        int n;
        corrupt = corr;
        build_model(s, corr, err, consumed, nwords);
        do_reset();
        if (prefix.size() > 0) begin
            foreach (prefix[i]) send_byte(prefix[i], gap, ok);
            do_reset();
        end
        for (int i = 0; i < consumed; i++) begin
            send_byte(s[i], gap, ok);
            if (!ok) break;
        end
        n = 0;
        if (!err) begin
            do begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end while (!done && n < 50);
            check({name, "_latency"}, 32'(n), 32'(1 + ((nwords > 0) ? (VER ? 2 : 1) : 0)));
            check({name, "_done"},     32'(done),     32'd1);
            check({name, "_proc_rst"}, 32'(proc_rst), 32'd0);
            check({name, "_error"},    32'(error),    32'd0);
        end else begin
            @(negedge clk);
            while (!error && n < 50) begin
                @(negedge clk);
                n++;
            end
            check({name, "_error"},    32'(error),    32'd1);
            check({name, "_proc_rst"}, 32'(proc_rst), 32'd1);
            check({name, "_done"},     32'(done),     32'd0);
        end
        check({name, "_term_val"}, 32'(ext_dmemreq_val), 32'd0);
        in_val  = 1'b1;
        in_data = 8'($urandom);
        repeat (3) begin
            check({name, "_stray_rdy"}, 32'(in_rdy), 32'd0);
            @(negedge clk);
        end
        in_val = 1'b0;
        check({name, "_nreq"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({name, "_type"}, 32'(obs_q[i].typ), 32'(exp_q[i].typ));
            check({name, "_addr"}, obs_q[i].addr, exp_q[i].addr);
            if (exp_q[i].typ) check({name, "_wdata"}, obs_q[i].data, exp_q[i].data);
        end
    endtask

    initial begin
        bq_t s;
        bq_t none;
        bq_t pre;
        int  nw;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        s = add_word(none, 32'd0);
        run_case("empty", none, s, 0, 1'b0);

        s = add_word(none, 32'd2);
        s = add_word(s, 32'hDEAD_BEEF);
        s = add_word(s, 32'h1234_5678);
        run_case("two_words", none, s, 0, 1'b0);
        run_case("two_words_gaps", none, s, 4, 1'b0);
        if (VER) run_case("verify_bad", none, s, 0, 1'b1);

        s = add_word(none, 32'h0000_0401);
        run_case("oversize", none, s, 0, 1'b0);

        pre = add_word(none, 32'd2);
        pre = add_word(pre, 32'h4433_2211);
        pre.push_back(8'h55);
        pre.push_back(8'h66);
        s = add_word(none, 32'd1);
        s = add_word(s, 32'hCAFE_F00D);
        run_case("reset_midload", pre, s, 0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            nw = $urandom_range(1, 6);
            s  = add_word(none, 32'(nw));
            for (int i = 0; i < nw; i++) s = add_word(s, $urandom);
            run_case("random", none, s, $urandom_range(0, 4), 1'b0);
        end

        s = add_word(none, 32'(MAXW));
        for (int i = 0; i < MAXW; i++) s = add_word(s, $urandom);
        run_case("max_words", none, s, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_proc_loader

`default_nettype wire

// File: doc/proc_loader.md
Name: proc_loader

Overview:
- Boot-time program loader directly upstream of the processor top level. It drives that block's external data-memory interface (ext_dmemreq_*) and its reset.
- Consumes a byte stream from a host link, such as a UART receiver. Assembles little-endian 32-bit words and writes them to consecutive word addresses.
- Holds the processor in reset until loading completes, then releases it.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be 4-byte aligned.
- MAX_WORDS, 1024, largest accepted word count; a header above this is an error.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_val  input  1  host byte valid
- in_rdy  output  1  loader ready for a byte
- in_data  input  8  host byte
- ext_dmemreq_val  output  1  memory request valid
- ext_dmemreq_type  output  1  0 = read, 1 = write
- ext_dmemreq_addr  output  32  byte address
- ext_dmemreq_wdata  output  32  write data
- ext_dmemreq_rdata  input  32  read data, combinational, same cycle as a read request
- proc_rst  output  1  processor reset; 1 = held in reset
- done  output  1  load complete, processor running
- error  output  1  load aborted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=HDR, byte_cnt=0, word_cnt=0, count=0, proc_rst=1, done=0, error=0, ext_dmemreq_val=0, in_rdy=1 (combinational from state).
- Stream format: 4-byte word count N, then N words. Every field is little-endian; the first byte received goes to bits [7:0].
- Byte transfer: a byte moves only when in_val && in_rdy. in_rdy=1 only in HDR and DATA.
- HDR state: shift accepted bytes into count. On the 4th byte, decide the next state with the byte's own value included:
  - N == 0 -> RUN
  - N > MAX_WORDS -> ERR
  - otherwise -> DATA
  - byte_cnt returns to 0.
- DATA state: shift bytes into the word register. On the 4th byte -> WRITE.
- WRITE state (exactly 1 cycle):
  - ext_dmemreq_val=1, type=1, addr=BASE_ADDR + 4*word_cnt (32-bit wrap), wdata=assembled word.
  - Then word_cnt increments. Next state is RUN if word_cnt+1 == N, else DATA.
- RUN state: terminal. proc_rst=0, done=1, in_rdy=0. Stray bytes are not accepted.
- ERR state: terminal. proc_rst=1, error=1, in_rdy=0.
- In RUN and ERR, ext_dmemreq_val=0, so the external interface is free for the processor's own use.
- Memory outputs outside request cycles: ext_dmemreq_val=0 everywhere except WRITE and VERIFY; addr/wdata/type are don't-care then but driven to 0.
- proc_rst: registered. It falls on the cycle after RUN is entered, so the first RUN cycle still has proc_rst=1.
- Throughput: one word every 5 cycles minimum (4 byte cycles plus WRITE), without verify.
- Idle gaps (in_val=0) in HDR or DATA: byte_cnt holds; no timeout.
- Reset mid-operation: returns to HDR on the next edge, all counters cleared, proc_rst=1. The partial load is abandoned; memory contents are not cleared.
- Reset in RUN: the processor goes back into reset and the loader awaits a new header.

Optional Feature:
- Macro: PROC_LOADER_VERIFY_EN.
- Defined:
  - WRITE is followed by a VERIFY cycle: ext_dmemreq_val=1, type=0, same addr.
  - ext_dmemreq_rdata is compared with the word register. Mismatch -> ERR; match -> RUN or DATA by the same rule as WRITE.
  - word_cnt increments in VERIFY instead of WRITE.
  - Throughput becomes one word per 6 cycles.
- Undefined: no VERIFY state; ext_dmemreq_rdata is unused.

Decomposition:
- Package proc_loader_pkg holds:
  - state enum: HDR, DATA, WRITE, VERIFY, RUN, ERR (3 bits)
  - localparams BYTES_PER_WORD=4 and WORD_BYTES_LOG2=2
- One sub-module, proc_loader_asm: 4-byte little-endian shift assembler.
  - Inputs: clk, rst, shift_en, clear, byte_in.
  - Outputs: word_out, full (asserted on the 4th shift).
  - Used for both the header and the data words.

Test Plan:
- Empty load: stream 00 00 00 00 -> no ext_dmemreq_val pulses; done=1 and proc_rst=0 two cycles after the last byte handshake.
- Two words, BASE_ADDR=0: stream 02 00 00 00, EF BE AD DE, 78 56 34 12 -> writes 0xDEADBEEF @0x0 then 0x12345678 @0x4, each a 1-cycle val pulse with type=1; then done.
- Backpressure and gaps: same stream with random in_val gaps -> identical writes; in_rdy=0 during every WRITE cycle; no byte lost or duplicated.
- Oversize header: count 0x00000401 with MAX_WORDS=1024 -> error=1, proc_rst stays 1, no writes, in_rdy=0.
- Reset mid-load: pulse rst after 2 data bytes, then send a fresh stream for 1 word 0xCAFEF00D -> single write of 0xCAFEF00D @BASE_ADDR; no stale bytes merged into it.
- With PROC_LOADER_VERIFY_EN: bench returns rdata = wdata ^ 1 on the read of word 0 -> error=1 after VERIFY, proc_rst=1. With correct rdata -> each write is followed by a type=0 read at the same addr, then done=1.
